// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared types and sizing helpers for the panda memory arbiter
package panda_pkg;

   // Which core interface owns a memory transaction
   typedef enum logic {
      ARB_INSTR = 1'b0,
      ARB_DATA  = 1'b1
   } arb_id_e;

   // Bits needed to hold the values 0..max_val inclusive
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to index depth entries; never below one bit
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/panda_fifo.sv
// rtl/panda_fifo.sv - small synchronous FIFO with occupancy-based full/empty
module panda_fifo
   import panda_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             push_en;
   logic             pop_en;

   // Overflowing pushes and underflowing pops are ignored so state stays consistent
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage array; contents are only meaningful while counted as occupied
   always_ff @(posedge clk_i) begin
      if (push_en) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_en) begin
            wptr_q <= ptr_inc(wptr_q);
         end
         if (pop_en) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         case ({push_en, pop_en})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/panda_mem_arbiter.sv
// rtl/panda_mem_arbiter.sv - shares one memory port between fetch and LSU with starvation guard
module panda_mem_arbiter
   import panda_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic [3:0]  data_we_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned SCW = cnt_width(STARVE_LIMIT);

   arb_id_e        owner_q;
   arb_id_e        sel;
   arb_id_e        head_id;
   logic           lock_q;
   logic [SCW-1:0] starve_cnt_q;
   logic           starve_hit;
   logic           xfer;
   logic           fifo_full;
   logic           fifo_empty;
   logic [0:0]     fifo_head;
   logic [0:0]     push_id;

   assign starve_hit = (starve_cnt_q == SCW'(STARVE_LIMIT));

   // Pick the owner: a stalled handshake keeps its owner, a starved fetch jumps the queue
   always_comb begin
      sel = ARB_INSTR;
      if (lock_q) begin
         sel = owner_q;
      end else if (starve_hit && instr_req_i) begin
         sel = ARB_INSTR;
      end else if (data_req_i) begin
         sel = ARB_DATA;
      end
   end

   // No issue while the ID queue is full, even if a response frees a slot this cycle
   assign mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full;
   assign xfer        = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = xfer & (sel == ARB_INSTR);
   assign data_gnt_o  = xfer & (sel == ARB_DATA);

   // Request payload mux; the bus is driven to zero when nothing is being requested
   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = '0;
      mem_wdata_o = '0;
      if (mem_req_o) begin
         if (sel == ARB_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   // Owner/lock registers hold the selection across a request that memory has not yet taken
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q <= ARB_DATA;
         lock_q  <= 1'b0;
      end else begin
         lock_q <= mem_req_o & ~mem_gnt_i;
         if (mem_req_o) begin
            owner_q <= sel;
         end
      end
   end

   // Count data wins over a waiting fetch; a fetch transfer resets the count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt_q <= '0;
      end else if (xfer) begin
         if (sel == ARB_INSTR) begin
            starve_cnt_q <= '0;
         end else if (instr_req_i && !starve_hit) begin
            starve_cnt_q <= starve_cnt_q + SCW'(1);
         end
      end
   end

   assign push_id = sel;

   panda_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (xfer),
      .wdata_i (push_id),
      .pop_i   (mem_rvalid_i),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_id = arb_id_e'(fifo_head);

   // Responses return in order; the queue head names the requester, stray responses are dropped
   assign instr_rvalid_o = mem_rvalid_i & ~fifo_empty & (head_id == ARB_INSTR);
   assign data_rvalid_o  = mem_rvalid_i & ~fifo_empty & (head_id == ARB_DATA);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// tb/tb_panda_mem_arbiter.sv - scoreboard bench for panda_mem_arbiter
module tb_panda_mem_arbiter;
   import panda_pkg::*;

   logic        clk_i;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic [3:0]  data_we_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_we_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   panda_mem_arbiter #(
      .MAX_OUTSTANDING (2),
      .STARVE_LIMIT    (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_addr_i    (data_addr_i),
      .data_we_i      (data_we_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_we_o       (mem_we_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } dreq_t;

   typedef struct {
      arb_id_e     id;
      logic [31:0] addr;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_op_t;

   logic [31:0] iq [$];
   dreq_t       dq [$];
   exp_t        sb [$];
   mem_op_t     mq [$];

   int    n_chk;
   int    n_pass;
   int    cyc;
   int    mem_lat;
   bit    drop_ok;
   string gnt_trace;
   string rsp_trace;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic check_trace(input string tag, input string got, input string exp);
      chk({tag, "_len"}, got.len(), exp.len());
      for (int i = 0; i < exp.len() && i < got.len(); i++) begin
         chk(tag, 32'(got[i]), 32'(exp[i]));
      end
   endtask

   task automatic push_exp(input arb_id_e id, input logic [31:0] addr);
      exp_t e;
      e.id   = id;
      e.addr = addr;
      sb.push_back(e);
   endtask

   task automatic apply_reqs();
      instr_req_i  = (iq.size() != 0);
      instr_addr_i = (iq.size() != 0) ? iq[0] : 32'h0;
      data_req_i   = (dq.size() != 0);
      data_addr_i  = (dq.size() != 0) ? dq[0].addr  : 32'h0;
      data_we_i    = (dq.size() != 0) ? dq[0].we    : 4'h0;
      data_wdata_i = (dq.size() != 0) ? dq[0].wdata : 32'h0;
   endtask

   task automatic monitor();
      mem_op_t op;
      exp_t    e;
      if (mem_req_o && mem_gnt_i) begin
         chk("gnt_onehot", 32'(instr_gnt_o) + 32'(data_gnt_o), 32'd1);
         op.addr = mem_addr_o;
         op.due  = cyc + mem_lat;
         mq.push_back(op);
      end else begin
         chk("gnt_idle", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
      end
      if (instr_gnt_o) begin
         gnt_trace = {gnt_trace, "I"};
         if (iq.size() != 0) begin
            chk("i_addr", mem_addr_o, iq[0]);
            chk("i_we", 32'(mem_we_o), 32'd0);
            void'(iq.pop_front());
         end else begin
            chk("i_gnt_spurious", 32'd1, 32'd0);
         end
      end else if (data_gnt_o) begin
         gnt_trace = {gnt_trace, "D"};
         if (dq.size() != 0) begin
            chk("d_addr", mem_addr_o, dq[0].addr);
            chk("d_we", 32'(mem_we_o), 32'(dq[0].we));
            chk("d_wdata", mem_wdata_o, dq[0].wdata);
            void'(dq.pop_front());
         end else begin
            chk("d_gnt_spurious", 32'd1, 32'd0);
         end
      end else begin
         gnt_trace = {gnt_trace, "-"};
      end
      if (instr_rvalid_o || data_rvalid_o) begin
         chk("rsp_both", 32'(instr_rvalid_o & data_rvalid_o), 32'd0);
         rsp_trace = {rsp_trace, instr_rvalid_o ? "I" : "D"};
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_id", 32'(data_rvalid_o), 32'(e.id == ARB_DATA));
            chk("rsp_data", instr_rvalid_o ? instr_rdata_o : data_rdata_o, mem_word(e.addr));
         end else begin
            chk("rsp_unexp", 32'd1, 32'd0);
         end
      end else begin
         rsp_trace = {rsp_trace, "-"};
      end
      if (mem_rvalid_i) begin
         if (drop_ok) begin
            chk("rsp_drop", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
         end else begin
            chk("rsp_route", 32'(instr_rvalid_o | data_rvalid_o), 32'd1);
         end
      end
   endtask

   task automatic mem_update();
      mem_op_t op;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'hDEAD_BEEF;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         op           = mq.pop_front();
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem_word(op.addr);
      end
   endtask

   task automatic step();
      #1;
      monitor();
      @(posedge clk_i);
      #1;
      cyc++;
      mem_update();
      apply_reqs();
   endtask

   task automatic start_test();
      gnt_trace = "";
      rsp_trace = "";
   endtask

   task automatic end_test();
      repeat (8) step();
      chk("sb_drained", sb.size(), 32'd0);
   endtask

   initial begin
      dreq_t d;
      n_chk = 0; n_pass = 0; cyc = 0; mem_lat = 1; drop_ok = 1'b0;
      rst_ni = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      apply_reqs();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
      chk("rst_rvalids", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_fifo_empty", 32'(dut.fifo_empty), 32'd1);
      chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
      rst_ni = 1'b1;
      #1;
      chk("idle_mem_req", 32'(mem_req_o), 32'd0);

      // fetch only, one-cycle memory
      start_test();
      iq.push_back(32'h0); iq.push_back(32'h4); iq.push_back(32'h8);
      push_exp(ARB_INSTR, 32'h0); push_exp(ARB_INSTR, 32'h4); push_exp(ARB_INSTR, 32'h8);
      apply_reqs();
      repeat (5) step();
      check_trace("t1_gnt", gnt_trace, "III--");
      check_trace("t1_rsp", rsp_trace, "-III-");
      end_test();

      // simultaneous requests: data first
      start_test();
      iq.push_back(32'h0);
      d.addr = 32'h100; d.we = 4'h0; d.wdata = 32'h0; dq.push_back(d);
      push_exp(ARB_DATA, 32'h100); push_exp(ARB_INSTR, 32'h0);
      apply_reqs();
      repeat (4) step();
      check_trace("t2_gnt", gnt_trace, "DI--");
      check_trace("t2_rsp", rsp_trace, "-DI-");
      end_test();

      // starvation guard
      start_test();
      iq.push_back(32'h180);
      for (int k = 0; k < 9; k++) begin
         d.addr  = 32'h200 + 32'(4 * k);
         d.we    = (k % 2 == 1) ? 4'hF : 4'h0;
         d.wdata = 32'hC0DE_0000 + 32'(k);
         dq.push_back(d);
         if (k == 4) push_exp(ARB_INSTR, 32'h180);
         push_exp(ARB_DATA, d.addr);
      end
      apply_reqs();
      for (int k = 0; k < 12; k++) begin
         if (k == 4) begin
            #1;
            chk("t3_starve_sat", 32'(dut.starve_cnt_q), 32'd4);
         end
         if (k == 5) begin
            #1;
            chk("t3_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
         end
         step();
      end
      check_trace("t3_gnt", gnt_trace, "DDDDIDDDDD--");
      check_trace("t3_rsp", rsp_trace, "-DDDDIDDDDD-");
      end_test();

      // stalled handshake keeps the fetch address until granted
      start_test();
      mem_gnt_i = 1'b0;
      iq.push_back(32'h40);
      push_exp(ARB_INSTR, 32'h40);
      apply_reqs();
      for (int k = 0; k < 6; k++) begin
         if (k == 2) begin
            d.addr = 32'h300; d.we = 4'h0; d.wdata = 32'h0; dq.push_back(d);
            push_exp(ARB_DATA, 32'h300);
         end
         if (k == 3) mem_gnt_i = 1'b1;
         apply_reqs();
         if (k < 4) begin
            #1;
            chk("t4_req", 32'(mem_req_o), 32'd1);
            chk("t4_addr", mem_addr_o, 32'h40);
         end
         step();
      end
      check_trace("t4_gnt", gnt_trace, "---ID-");
      check_trace("t4_rsp", rsp_trace, "----ID");
      end_test();

      // outstanding limit with slow responses
      start_test();
      mem_lat = 5;
      iq.push_back(32'h10); iq.push_back(32'h14); iq.push_back(32'h18);
      push_exp(ARB_INSTR, 32'h10); push_exp(ARB_INSTR, 32'h14); push_exp(ARB_INSTR, 32'h18);
      apply_reqs();
      for (int k = 0; k < 13; k++) begin
         #1;
         chk("t5_mem_req", 32'(mem_req_o), 32'(k < 2 || k == 6));
         step();
      end
      check_trace("t5_gnt", gnt_trace, "II----I------");
      check_trace("t5_rsp", rsp_trace, "-----II----I-");
      end_test();

      // reset with two transactions in flight
      start_test();
      iq.push_back(32'h80);
      d.addr = 32'h500; d.we = 4'h0; d.wdata = 32'h0; dq.push_back(d);
      d.addr = 32'h504; dq.push_back(d);
      apply_reqs();
      repeat (2) step();
      #1;
      chk("t6_starve_pre", 32'(dut.starve_cnt_q), 32'd2);
      chk("t6_full_block", 32'(mem_req_o), 32'd0);
      check_trace("t6_gnt_pre", gnt_trace, "DD");
      rst_ni = 1'b0;
      iq.delete();
      dq.delete();
      apply_reqs();
      #1;
      chk("t6_fifo_empty", 32'(dut.fifo_empty), 32'd1);
      chk("t6_starve_rst", 32'(dut.starve_cnt_q), 32'd0);
      step();
      rst_ni = 1'b1;
      drop_ok = 1'b1;
      start_test();
      repeat (5) step();
      drop_ok = 1'b0;
      check_trace("t6_gnt_post", gnt_trace, "-----");
      check_trace("t6_rsp_post", rsp_trace, "-----");
      mem_lat = 1;
      start_test();
      iq.push_back(32'h90);
      push_exp(ARB_INSTR, 32'h90);
      apply_reqs();
      repeat (3) step();
      check_trace("t6_gnt_new", gnt_trace, "I--");
      check_trace("t6_rsp_new", rsp_trace, "-I-");
      end_test();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
